i2c_slave_buffered: RTL and testbench

Parametrised I2C target (slave) for the board-side I2C link. Adds buffering, repeated-START support, input glitch filtering and flow-controlled NACK to the single-byte slave. Sits between the open-drain SCL/SDA pads and downstream threads, exchanging bytes through an RX FIFO and a TX FIFO with valid/ready handshakes. Supports standard and fast mode; no clock stretching.

---
 rtl/i2c_slave_buffered.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_slave_buffered.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_buffered.sv
// Buffered I2C target: pad conditioning, START/STOP detection, byte engine and RX/TX FIFOs.
// Bytes flow through valid/ready FIFOs; a full RX FIFO NACKs, an empty TX FIFO returns 0xFF.
module i2c_slave_buffered #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h49,
    parameter int         RX_DEPTH    = 4,
    parameter int         TX_DEPTH    = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_overflow,
    output logic       tx_underrun
);
    localparam int FCW  = $clog2(FILTER + 1);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXCW = $clog2(RX_DEPTH + 1);
    localparam int TXCW = $clog2(TX_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             pad_raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [FCW-1:0]         filt_cnt [2];
    logic [1:0]             filt_q, prev_q;
    logic                   scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;

    logic [6:0] shift_q;
    logic [7:0] byte_in;
    logic [2:0] bit_cnt;
    logic       rw_q, ack_seen;

    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RXAW-1:0] rx_wr, rx_rd;
    logic [RXCW-1:0] rx_count;
    logic            rx_full, rx_push, rx_drop, rx_pop;

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TXAW-1:0] tx_wr, tx_rd;
    logic [TXCW-1:0] tx_count;
    logic            tx_empty, tx_push, tx_pop, tx_load;
    logic [7:0]      tx_head;

    assign pad_raw = {scl_in, sda_in};

    // Index 1 is SCL, index 0 is SDA; a line flips only after FILTER consecutive opposite samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i]   <= '1;
                filt_cnt[i] <= '0;
            end
            filt_q <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad_raw[i]};
                if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FCW'(FILTER - 1)) begin
                    filt_q[i]   <= ~filt_q[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + FCW'(1);
                end
            end
        end
    end

    assign scl_f    = filt_q[1];
    assign sda_f    = filt_q[0];
    assign scl_rise = scl_f & ~prev_q[1];
    assign scl_fall = ~scl_f & prev_q[1];
    assign start_c  = scl_f & prev_q[1] & prev_q[0] & ~sda_f;
    assign stop_c   = scl_f & prev_q[1] & ~prev_q[0] & sda_f;
    assign byte_in  = {shift_q, sda_f};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ACK states use sda_oe itself to tell the ACK-opening fall from the ACK-closing fall.
    always_comb begin
        state_d = state_q;
        if (stop_c) begin
            state_d = IDLE;
        end else if (start_c) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && bit_cnt == 3'd7)
                              state_d = (byte_in[7:1] == SLAVE_ADDR) ? ACK_ADDR : WAIT_STOP;
                ACK_ADDR: if (scl_fall && sda_oe) state_d = rw_q ? TX_BYTE : RX_BYTE;
                RX_BYTE:  if (scl_rise && bit_cnt == 3'd7) state_d = rx_full ? WAIT_STOP : RX_ACK;
                RX_ACK:   if (scl_fall && sda_oe) state_d = RX_BYTE;
                TX_BYTE:  if (scl_fall && bit_cnt == 3'd7) state_d = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_f)          state_d = WAIT_STOP;
                    else if (scl_fall && ack_seen)  state_d = TX_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        rx_push = 1'b0;
        rx_drop = 1'b0;
        case (state_q)
            ACK_ADDR, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK: busy = 1'b1;
            default: ;
        endcase
        if (state_q == RX_BYTE && scl_rise && bit_cnt == 3'd7) begin
            rx_push = ~rx_full;
            rx_drop = rx_full;
        end
        tx_load = (state_d == TX_BYTE) && (state_q != TX_BYTE);
    end

    // The first TX bit is driven on the same fall that loads the byte, so it is ready before the next rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            rw_q        <= 1'b0;
            ack_seen    <= 1'b0;
            sda_oe      <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overflow <= rx_drop;
            tx_underrun <= tx_load & tx_empty;
            if (start_c || stop_c) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
            end else if (tx_load) begin
                shift_q  <= tx_head[6:0];
                sda_oe   <= ~tx_head[7];
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, RX_BYTE: if (scl_rise) begin
                        shift_q <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (state_q == ADDR && bit_cnt == 3'd7) rw_q <= byte_in[0];
                    end
                    ACK_ADDR, RX_ACK: if (scl_fall) begin
                        sda_oe  <= ~sda_oe;
                        bit_cnt <= '0;
                    end
                    TX_BYTE: if (scl_fall) begin
                        sda_oe  <= (bit_cnt == 3'd7) ? 1'b0 : ~shift_q[6];
                        shift_q <= {shift_q[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    TX_ACK: if (scl_rise) ack_seen <= ~sda_f;
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign rx_full  = (rx_count == RXCW'(RX_DEPTH));
    assign rx_valid = (rx_count != '0);
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_data  = rx_valid ? rx_mem[rx_rd] : 8'h00;

    assign tx_empty = (tx_count == '0);
    assign tx_ready = (tx_count != TXCW'(TX_DEPTH));
    assign tx_push  = tx_valid & tx_ready;
    assign tx_pop   = tx_load & ~tx_empty;
    assign tx_head  = tx_empty ? 8'hFF : tx_mem[tx_rd];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + RXAW'(1);
            if (rx_pop)  rx_rd <= rx_rd + RXAW'(1);
            rx_count <= rx_count + RXCW'(rx_push) - RXCW'(rx_pop);
            if (tx_push) tx_wr <= tx_wr + TXAW'(1);
            if (tx_pop)  tx_rd <= tx_rd + TXAW'(1);
            tx_count <= tx_count + TXCW'(tx_push) - TXCW'(tx_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr] <= byte_in;
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end
endmodule

// File: tb/tb_i2c_slave_buffered.sv
// Directed bench: a bit-banged I2C master drives the target and checks ACKs, FIFO data and pulses.
module tb_i2c_slave_buffered;
    localparam int HALF = 20;
    localparam int QTR  = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       rx_overflow;
    logic       tx_underrun;

    int tests_run = 0;
    int tests_failed = 0;
    int ovf_cnt = 0, und_cnt = 0, oe_cnt = 0, rxv_cnt = 0, busy_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_buffered dut (
        .clock       (clock),
        .reset       (reset),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rx_overflow) ovf_cnt  <= ovf_cnt + 1;
        if (tx_underrun) und_cnt  <= und_cnt + 1;
        if (sda_oe)      oe_cnt   <= oe_cnt + 1;
        if (rx_valid)    rxv_cnt  <= rxv_cnt + 1;
        if (busy)        busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clks(HALF);
        sda_m = 1'b0; wait_clks(HALF);
        scl_m = 1'b0; wait_clks(QTR);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_clks(QTR);
        scl_m = 1'b1; wait_clks(HALF);
        sda_m = 1'b0; wait_clks(HALF);
        scl_m = 1'b0; wait_clks(QTR);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(QTR);
        scl_m = 1'b1; wait_clks(HALF);
        sda_m = 1'b1; wait_clks(HALF);
    endtask

    // A glitch pulls SCL low for 2 clocks in the middle of the high phase.
    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; wait_clks(QTR);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clks(8);
            scl_m = 1'b0; wait_clks(2);
            scl_m = 1'b1; wait_clks(HALF - 10);
        end else begin
            wait_clks(HALF);
        end
        scl_m = 1'b0; wait_clks(QTR);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clks(QTR);
        scl_m = 1'b1; wait_clks(HALF / 2);
        b = sda_line;
        wait_clks(HALF / 2);
        scl_m = 1'b0; wait_clks(QTR);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_at);
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack, 1'b0);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
        wait_clks(1);
    endtask

    task automatic pop_rx(output logic [7:0] d);
        int waited;
        waited = 0;
        while (!rx_valid && waited < 20) begin
            wait_clks(1);
            waited++;
        end
        d = rx_valid ? rx_data : 8'hxx;
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] pat;
        int         oe0, rxv0, busy0, ovf0, und0;

        reset = 1'b0;
        wait_clks(5);
        checkOutput("reset_sda_oe", sda_oe, 0);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_tx_ready", tx_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pulses", {rx_overflow, tx_underrun}, 0);
        reset = 1'b1;
        wait_clks(5);

        // Plain write of two bytes with rx_ready held low
        bus_start();
        write_byte(8'h92, -1, ack); checkOutput("wr_addr_ack", ack, 1);
        checkOutput("wr_busy", busy, 1);
        write_byte(8'hA5, -1, ack); checkOutput("wr_a5_ack", ack, 1);
        write_byte(8'h3C, -1, ack); checkOutput("wr_3c_ack", ack, 1);
        bus_stop();
        checkOutput("wr_busy_after_stop", busy, 0);
        pop_rx(d); checkOutput("wr_pop0", d, 8'hA5);
        pop_rx(d); checkOutput("wr_pop1", d, 8'h3C);
        checkOutput("wr_rx_empty", rx_valid, 0);

        // Wrong address
        oe0 = oe_cnt; rxv0 = rxv_cnt; busy0 = busy_cnt;
        bus_start();
        write_byte(8'h90, -1, ack); checkOutput("bad_addr_nack", ack, 0);
        write_byte(8'h55, -1, ack); checkOutput("bad_data_nack", ack, 0);
        bus_stop();
        checkOutput("bad_oe_cycles", oe_cnt - oe0, 0);
        checkOutput("bad_rxv_cycles", rxv_cnt - rxv0, 0);
        checkOutput("bad_busy_cycles", busy_cnt - busy0, 0);

        // Overflow: five bytes into a four-entry FIFO
        ovf0 = ovf_cnt;
        bus_start();
        write_byte(8'h92, -1, ack); checkOutput("ovf_addr_ack", ack, 1);
        for (int i = 1; i <= 5; i++) begin
            pat = 8'(i);
            write_byte(pat, -1, ack);
            checkOutput($sformatf("ovf_ack%0d", i), ack, (i <= 4) ? 1 : 0);
        end
        bus_stop();
        checkOutput("ovf_pulses", ovf_cnt - ovf0, 1);
        for (int i = 1; i <= 4; i++) begin
            pop_rx(d);
            checkOutput($sformatf("ovf_pop%0d", i), d, i);
        end
        checkOutput("ovf_rx_empty", rx_valid, 0);

        // Read three bytes from a FIFO holding two
        push_tx(8'h5A);
        push_tx(8'hC3);
        und0 = und_cnt;
        bus_start();
        write_byte(8'h93, -1, ack); checkOutput("rd_addr_ack", ack, 1);
        read_byte(1'b1, d); checkOutput("rd_byte0", d, 8'h5A);
        read_byte(1'b1, d); checkOutput("rd_byte1", d, 8'hC3);
        read_byte(1'b0, d); checkOutput("rd_byte2", d, 8'hFF);
        checkOutput("rd_busy_after_nack", busy, 0);
        checkOutput("rd_underruns", und_cnt - und0, 1);
        bus_stop();
        checkOutput("rd_tx_ready", tx_ready, 1);

        // Write then repeated START into a read
        push_tx(8'h77);
        und0 = und_cnt;
        bus_start();
        write_byte(8'h92, -1, ack); checkOutput("rs_waddr_ack", ack, 1);
        write_byte(8'h10, -1, ack); checkOutput("rs_data_ack", ack, 1);
        bus_rstart();
        write_byte(8'h93, -1, ack); checkOutput("rs_raddr_ack", ack, 1);
        read_byte(1'b0, d); checkOutput("rs_read", d, 8'h77);
        bus_stop();
        checkOutput("rs_underruns", und_cnt - und0, 0);
        pop_rx(d); checkOutput("rs_rx", d, 8'h10);

        // SCL glitches inside the high phase must not shift extra bits
        bus_start();
        write_byte(8'h92, 3, ack); checkOutput("gl_addr_ack", ack, 1);
        write_byte(8'h5C, 5, ack); checkOutput("gl_data_ack", ack, 1);
        bus_stop();
        pop_rx(d); checkOutput("gl_rx", d, 8'h5C);

        // Asynchronous reset in the middle of an ACK
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44);
        checkOutput("rst_tx_full", tx_ready, 0);
        bus_start();
        write_byte(8'h92, -1, ack); checkOutput("rst_addr_ack", ack, 1);
        pat = 8'h33;
        for (int i = 7; i >= 0; i--) write_bit(pat[i], 1'b0);
        sda_m = 1'b1;
        checkOutput("rst_oe_before", sda_oe, 1);
        checkOutput("rst_rxv_before", rx_valid, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_oe_after", sda_oe, 0);
        checkOutput("rst_rxv_after", rx_valid, 0);
        checkOutput("rst_tx_ready_after", tx_ready, 1);
        checkOutput("rst_busy_after", busy, 0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(3);
        bus_stop();
        und0 = und_cnt;
        bus_start();
        write_byte(8'h93, -1, ack); checkOutput("rst_raddr_ack", ack, 1);
        read_byte(1'b0, d); checkOutput("rst_read_empty", d, 8'hFF);
        checkOutput("rst_underrun", und_cnt - und0, 1);
        bus_stop();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
